// File: rtl/mem_io_responder_pkg.sv
// Shared constants, types and address-decode helper for the memory/IO responder.
package mem_io_responder_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEC_W  = 18;

   localparam logic [ADDR_W-1:0] IO_BASE = 32'h30000;
   localparam logic [ADDR_W-1:0] IO_CLK  = 32'h30004;

   // Source of the registered read byte presented on mem_din.
   typedef enum logic {
      SrcRam,
      SrcIo
   } rd_src_e;

   function automatic logic io_decode(input logic [1:0] a_hi);
      return a_hi == 2'b11;
   endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU byte bus plus UART FIFO handshakes and status flags of the responder.
interface mem_io_responder_if;

   logic [mem_io_responder_pkg::ADDR_W-1:0] mem_a;
   logic                                    mem_wr;
   logic [mem_io_responder_pkg::DATA_W-1:0] mem_dout;
   logic [mem_io_responder_pkg::DATA_W-1:0] mem_din;
   logic                                    io_buffer_full;
   logic [7:0]                              rx_data;
   logic                                    rx_valid;
   logic                                    rx_ready;
   logic [7:0]                              tx_data;
   logic                                    tx_valid;
   logic                                    tx_ready;
   logic                                    program_stop;
   logic                                    tx_overflow;

   modport slave (
      input  mem_a, mem_wr, mem_dout, rx_data, rx_valid, tx_ready,
      output mem_din, io_buffer_full, rx_ready, tx_data, tx_valid, program_stop, tx_overflow
   );

   modport master (
      output mem_a, mem_wr, mem_dout, rx_data, rx_valid, tx_ready,
      input  mem_din, io_buffer_full, rx_ready, tx_data, tx_valid, program_stop, tx_overflow
   );

endinterface

// File: rtl/byte_fifo.sv
// Power-of-two synchronous FIFO; a pop frees space for a same-cycle push when full.
module byte_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         din_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned Aw = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [Aw-1:0]    wr_ptr_q, rd_ptr_q;
   logic [Aw:0]      count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (Aw+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + Aw'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + Aw'(1);
         if (do_push && !do_pop) begin
            count_q <= count_q + (Aw+1)'(1);
         end else if (!do_push && do_pop) begin
            count_q <= count_q - (Aw+1)'(1);
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/mem_io_responder.sv
// Main RAM plus memory-mapped UART FIFOs, cycle counter and stop flag behind the CPU byte bus.
module mem_io_responder
   import mem_io_responder_pkg::*;
#(
   parameter int unsigned RAM_ADDR_W = 17,
   parameter int unsigned RX_DEPTH   = 16,
   parameter int unsigned TX_DEPTH   = 16
) (
   input logic                clk_in,
   input logic                rst_in,
   mem_io_responder_if.slave  bus
);

   localparam int unsigned     RxCw        = $clog2(RX_DEPTH) + 1;
   localparam int unsigned     TxCw        = $clog2(TX_DEPTH) + 1;
   localparam logic [TxCw-1:0] TxHighWater = TxCw'(TX_DEPTH - 2);
   localparam logic [DEC_W-1:0] RxAddr     = IO_BASE[DEC_W-1:0];
   localparam logic [DEC_W-1:0] ClkAddr    = IO_CLK[DEC_W-1:0];

   logic [DEC_W-1:0]  addr;
   logic              unused_addr_hi;
   logic              is_io, ram_hit, is_rx, is_clk, new_rx;
   logic              rd, wr;

   logic [DATA_W-1:0] ram_q [2**RAM_ADDR_W];
   logic [DATA_W-1:0] ram_rdata_q;
   rd_src_e           src_q, src_d;
   logic [7:0]        io_rdata_q, io_rdata_d;
   logic [31:0]       cnt_q;
   logic [23:0]       shadow_q, shadow_d;
   logic [DEC_W-1:0]  prev_a_q;
   logic              prev_wr_q;
   logic              stop_q, stop_d, ovf_q, ovf_d;

   logic              rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0]        rx_head;
   logic [RxCw-1:0]   rx_count_unused;
   logic              tx_push, tx_pop, tx_full, tx_empty;
   logic [7:0]        tx_din, tx_head;
   logic [TxCw-1:0]   tx_count;

   assign addr           = bus.mem_a[DEC_W-1:0];
   assign unused_addr_hi = ^bus.mem_a[ADDR_W-1:DEC_W];
   assign wr             = bus.mem_wr;
   assign rd             = ~bus.mem_wr;
   assign is_io          = io_decode(addr[DEC_W-1:DEC_W-2]);
   assign ram_hit        = ~is_io && ((addr >> RAM_ADDR_W) == '0);
   assign is_rx          = (addr == RxAddr);
   assign is_clk         = (addr[DEC_W-1:2] == ClkAddr[DEC_W-1:2]);
   // A held 0x30000 read pops only on its first cycle.
   assign new_rx         = ~((prev_a_q == RxAddr) && !prev_wr_q);

   always_comb begin
      src_d      = src_q;
      io_rdata_d = io_rdata_q;
      shadow_d   = shadow_q;
      stop_d     = stop_q;
      ovf_d      = ovf_q;
      tx_push    = 1'b0;
      tx_din     = '0;
      rx_pop     = 1'b0;
      if (wr) begin
         if (is_rx && bus.mem_dout != '0) begin
            tx_push = 1'b1;
            tx_din  = bus.mem_dout;
         end else if (is_clk && addr[1:0] == 2'd0 && !stop_q) begin
            tx_push = 1'b1;
            stop_d  = 1'b1;
         end
      end else if (ram_hit) begin
         src_d = SrcRam;
      end else begin
         src_d      = SrcIo;
         io_rdata_d = '0;
         if (is_rx) begin
            io_rdata_d = rx_empty ? '0 : rx_head;
            rx_pop     = new_rx & ~rx_empty;
         end else if (is_clk) begin
            unique case (addr[1:0])
               2'd0: begin
                  io_rdata_d = cnt_q[7:0];
                  shadow_d   = cnt_q[31:8];
               end
               2'd1: io_rdata_d = shadow_q[7:0];
               2'd2: io_rdata_d = shadow_q[15:8];
               2'd3: io_rdata_d = shadow_q[23:16];
            endcase
         end
      end
      if (tx_push && tx_full && !tx_pop) ovf_d = 1'b1;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         src_q      <= SrcIo;
         io_rdata_q <= '0;
         cnt_q      <= '0;
         shadow_q   <= '0;
         prev_a_q   <= '0;
         prev_wr_q  <= 1'b1;
         stop_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         src_q      <= src_d;
         io_rdata_q <= io_rdata_d;
         cnt_q      <= cnt_q + 32'd1;
         shadow_q   <= shadow_d;
         prev_a_q   <= addr;
         prev_wr_q  <= wr;
         stop_q     <= stop_d;
         ovf_q      <= ovf_d;
      end
   end

   // RAM is left uninitialised; its read register only matters while src_q selects it.
   always_ff @(posedge clk_in) begin
      if (!rst_in && wr && ram_hit) ram_q[addr[RAM_ADDR_W-1:0]] <= bus.mem_dout;
      if (rd && ram_hit) ram_rdata_q <= ram_q[addr[RAM_ADDR_W-1:0]];
   end

   assign rx_push = bus.rx_valid & ~rx_full;
   assign tx_pop  = ~tx_empty & bus.tx_ready;

   byte_fifo #(
      .DEPTH (RX_DEPTH),
      .WIDTH (8)
   ) u_rx_fifo (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .push_i  (rx_push),
      .din_i   (bus.rx_data),
      .pop_i   (rx_pop),
      .dout_o  (rx_head),
      .full_o  (rx_full),
      .empty_o (rx_empty),
      .count_o (rx_count_unused)
   );

   byte_fifo #(
      .DEPTH (TX_DEPTH),
      .WIDTH (8)
   ) u_tx_fifo (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .push_i  (tx_push),
      .din_i   (tx_din),
      .pop_i   (tx_pop),
      .dout_o  (tx_head),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .count_o (tx_count)
   );

   assign bus.mem_din        = (src_q == SrcRam) ? ram_rdata_q : io_rdata_q;
   assign bus.rx_ready       = ~rx_full;
   assign bus.tx_valid       = ~tx_empty;
   assign bus.tx_data        = tx_empty ? '0 : tx_head;
   assign bus.io_buffer_full = (tx_count >= TxHighWater);
   assign bus.program_stop   = stop_q;
   assign bus.tx_overflow    = ovf_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench: directed and randomized traffic against queue/array reference models.
module tb_mem_io_responder;
   import mem_io_responder_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   logic [31:0] cyc_m;

   logic [7:0]  ram_m [int];
   logic [7:0]  rx_q [$];
   logic [7:0]  tx_q [$];
   logic        ovf_m, stop_m;

   mem_io_responder_if bus ();

   mem_io_responder #(
      .RAM_ADDR_W (17),
      .RX_DEPTH   (16),
      .TX_DEPTH   (16)
   ) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Cycles elapsed since the last reset edge.
   always @(posedge clk) cyc_m <= rst ? 32'd0 : cyc_m + 32'd1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input logic [31:0] a, input logic w, input logic [7:0] d);
      bus.mem_a    = a;
      bus.mem_wr   = w;
      bus.mem_dout = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cycle(32'h0, 1'b0, 8'h00);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_mem_din"}, bus.mem_din, 8'h00);
      check({pfx, "_tx_valid"}, bus.tx_valid, 1'b0);
      check({pfx, "_tx_data"}, bus.tx_data, 8'h00);
      check({pfx, "_rx_ready"}, bus.rx_ready, 1'b1);
      check({pfx, "_io_full"}, bus.io_buffer_full, 1'b0);
      check({pfx, "_stop"}, bus.program_stop, 1'b0);
      check({pfx, "_tx_ovf"}, bus.tx_overflow, 1'b0);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      idle();
      rst = 1'b0;
      tx_q.delete();
      rx_q.delete();
      ovf_m  = 1'b0;
      stop_m = 1'b0;
   endtask

   // One bus cycle with the tx FIFO modelled as a bounded queue.
   task automatic tx_step(input logic [31:0] a, input logic w, input logic [7:0] d,
                          input logic rdy);
      logic       pop, want;
      logic [7:0] pd;
      pop  = (tx_q.size() > 0) && rdy;
      want = 1'b0;
      pd   = 8'h00;
      if (w && a == IO_BASE && d != 8'h00) begin
         want = 1'b1;
         pd   = d;
      end else if (w && a == IO_CLK && !stop_m) begin
         want   = 1'b1;
         stop_m = 1'b1;
      end
      bus.tx_ready = rdy;
      cycle(w ? a : 32'h0, w, d);
      if (pop) void'(tx_q.pop_front());
      if (want) begin
         if (tx_q.size() < 16) tx_q.push_back(pd);
         else ovf_m = 1'b1;
      end
      check("tx_valid", bus.tx_valid, tx_q.size() > 0);
      check("tx_data", bus.tx_data, (tx_q.size() > 0) ? tx_q[0] : 8'h00);
      check("io_buffer_full", bus.io_buffer_full, tx_q.size() >= 14);
      check("tx_overflow", bus.tx_overflow, ovf_m);
      check("program_stop", bus.program_stop, stop_m);
   endtask

   task automatic rx_read(input string tag);
      cycle(IO_BASE, 1'b0, 8'h00);
      check(tag, bus.mem_din, (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00);
   endtask

   initial begin
      logic [31:0] a, exp_cnt;
      logic [7:0]  d;
      logic [7:0]  b [4];

      rst          = 1'b1;
      bus.mem_a    = '0;
      bus.mem_wr   = 1'b0;
      bus.mem_dout = '0;
      bus.rx_data  = '0;
      bus.rx_valid = 1'b0;
      bus.tx_ready = 1'b0;
      ovf_m        = 1'b0;
      stop_m       = 1'b0;
      idle();
      idle();
      check_reset_outputs("reset");
      rst = 1'b0;

      // RAM write/read and out-of-range aliasing
      cycle(32'h10, 1'b1, 8'hA5);
      cycle(32'h10, 1'b0, 8'h00);
      check("ram_rd_after_wr", bus.mem_din, 8'hA5);
      cycle(32'h20010, 1'b0, 8'h00);
      check("ram_oor_read", bus.mem_din, 8'h00);
      cycle(32'h20010, 1'b1, 8'h77);
      cycle(32'h10, 1'b0, 8'h00);
      check("ram_oor_write_ignored", bus.mem_din, 8'hA5);

      for (int i = 0; i < 128; i++) begin
         a = (i < 64) ? 32'(i) : 32'h1FFC0 + 32'(i - 64);
         d = 8'($urandom);
         cycle(a, 1'b1, d);
         ram_m[int'(a)] = d;
      end
      for (int i = 0; i < 100; i++) begin
         a = 32'($urandom_range(0, 63)) + ($urandom_range(0, 1) != 0 ? 32'h1FFC0 : 32'h0);
         if ($urandom_range(0, 1) != 0) begin
            d = 8'($urandom);
            cycle(a, 1'b1, d);
            ram_m[int'(a)] = d;
         end else begin
            cycle(a, 1'b0, 8'h00);
            check("ram_random_read", bus.mem_din, ram_m[int'(a)]);
         end
      end

      // RX FIFO: pops on new accesses only
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h41;
      idle();
      bus.rx_data  = 8'h42;
      idle();
      bus.rx_valid = 1'b0;
      rx_q.push_back(8'h41);
      rx_q.push_back(8'h42);
      rx_read("rx_first");
      idle();
      rx_read("rx_second");
      idle();
      rx_read("rx_empty");
      idle();

      bus.rx_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.rx_data = 8'($urandom);
         rx_q.push_back(bus.rx_data);
         idle();
      end
      bus.rx_valid = 1'b0;
      rx_read("rx_hold_first");
      cycle(IO_BASE, 1'b0, 8'h00);
      cycle(IO_BASE, 1'b0, 8'h00);
      idle();
      rx_read("rx_hold_popped_once");
      idle();
      rx_read("rx_hold_then_empty");

      bus.rx_valid = 1'b1;
      for (int i = 0; i < 18; i++) begin
         bus.rx_data = 8'($urandom);
         if (rx_q.size() < 16) rx_q.push_back(bus.rx_data);
         idle();
      end
      bus.rx_valid = 1'b0;
      check("rx_ready_full", bus.rx_ready, 1'b0);
      for (int i = 0; i < 17; i++) begin
         idle();
         rx_read("rx_drain");
      end
      check("rx_ready_after_drain", bus.rx_ready, 1'b1);

      // Randomized tx traffic against the queue model
      for (int i = 0; i < 200; i++) begin
         d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         tx_step(IO_BASE, $urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 3);
      end
      for (int i = 0; i < 18; i++) tx_step(IO_BASE, 1'b0, 8'h00, 1'b1);

      // Directed fill to the near-full threshold and past full
      reset_dut();
      check("tx_ovf_cleared", bus.tx_overflow, 1'b0);
      for (int k = 1; k <= 17; k++) begin
         tx_step(IO_BASE, 1'b1, 8'(k), 1'b0);
         if (k == 13) check("io_full_at_13", bus.io_buffer_full, 1'b0);
         if (k == 14) check("io_full_at_14", bus.io_buffer_full, 1'b1);
         if (k == 16) check("no_ovf_at_16", bus.tx_overflow, 1'b0);
         if (k == 17) check("ovf_at_17", bus.tx_overflow, 1'b1);
      end
      tx_step(IO_BASE, 1'b1, 8'h00, 1'b0);
      check("tx_head_first", bus.tx_data, 8'h01);
      for (int i = 0; i < 17; i++) tx_step(IO_BASE, 1'b0, 8'h00, 1'b1);
      check("tx_drained", bus.tx_valid, 1'b0);

      // Cycle counter with shadowed upper bytes
      reset_dut();
      cycle(32'h30007, 1'b0, 8'h00);
      check("shadow_after_reset", bus.mem_din, 8'h00);
      for (int i = 0; i < 6000 && cyc_m < 32'h1234; i++) idle();
      for (int rep = 0; rep < 3; rep++) begin
         exp_cnt = cyc_m;
         for (int j = 0; j < 4; j++) begin
            cycle(IO_CLK + 32'(j), 1'b0, 8'h00);
            b[j] = bus.mem_din;
         end
         check("cycle_counter", {b[3], b[2], b[1], b[0]}, exp_cnt);
         for (int i = $urandom_range(1, 400); i > 0; i--) idle();
      end

      // Program stop, then reset mid-stream
      tx_step(IO_CLK, 1'b1, 8'hFF, 1'b0);
      check("stop_set", bus.program_stop, 1'b1);
      check("stop_pushes_zero", bus.tx_valid, 1'b1);
      tx_step(IO_CLK, 1'b1, 8'hFF, 1'b0);
      tx_step(IO_BASE, 1'b1, 8'h33, 1'b0);
      for (int i = 0; i < 3; i++) tx_step(IO_BASE, 1'b0, 8'h00, 1'b1);
      check("stop_sticky", bus.program_stop, 1'b1);

      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h5C;
      tx_step(IO_BASE, 1'b1, 8'h66, 1'b0);
      tx_step(IO_BASE, 1'b1, 8'h67, 1'b0);
      bus.rx_valid = 1'b0;
      cycle(32'h10, 1'b0, 8'h00);
      rst = 1'b1;
      cycle(32'h10, 1'b0, 8'h00);
      check_reset_outputs("midrst");
      rst = 1'b0;
      rx_q.delete();
      rx_read("rx_after_reset");
      check("tx_after_reset", bus.tx_valid, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the CPU's byte-wide bus (mem_a, mem_wr, mem_dout, mem_din).
- Holds the main RAM and the memory-mapped I/O.
- Answers the fetcher's reads with one-cycle latency and absorbs writes in the same cycle.
- Maps 0x30000/0x30004 to UART rx/tx FIFOs, a cycle counter and a program-stop flag; drives io_buffer_full back to the CPU.

Parameters:
- RAM_ADDR_W, 17, RAM byte-address width (128 KB).
- RX_DEPTH, 16, input FIFO entries (power of 2).
- TX_DEPTH, 16, output FIFO entries (power of 2, >=4).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- mem_a  in  32  CPU address (only [17:0] decoded)
- mem_wr  in  1  1 = write this cycle, 0 = read
- mem_dout  in  8  CPU write data
- mem_din  out  8  read data, valid the cycle after the address
- io_buffer_full  out  1  tx FIFO near-full, to CPU
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  rx FIFO not full
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx FIFO not empty
- tx_ready  in  1  transmitter accepts tx_data
- program_stop  out  1  sticky, set by a write to 0x30004
- tx_overflow  out  1  sticky, a tx write was dropped

Behaviour:
- Address decode:
  - io = (mem_a[17:16]==2'b11).
  - Otherwise RAM, indexed by mem_a[RAM_ADDR_W-1:0]; an address >= 2^RAM_ADDR_W reads 0 and ignores writes.
- RAM write: when mem_wr=1, mem_dout is stored at the rising edge. No response. A read of the same address in the next cycle returns the new byte.
- Read: when mem_wr=0, mem_din is registered at the edge and holds the addressed byte through the following cycle. Latency is exactly 1, and every cycle is a read when mem_wr=0.
- Read 0x30000:
  - Returns the rx FIFO head, or 0x00 if empty.
  - Pops only on a new access: (mem_a,mem_wr) in the previous cycle != (0x30000,0).
  - CPU contract: at least one non-0x30000 cycle between consecutive input reads.
- Write 0x30000:
  - Data 0x00 is ignored.
  - Otherwise the byte is pushed to the tx FIFO.
  - If the FIFO is full, the byte is dropped and tx_overflow is set.
- Write 0x30004: sets program_stop and pushes 0x00 to the tx FIFO, subject to the same full rule. Later writes are no-ops.
- Reads 0x30004..0x30007 (cycle counter):
  - 0x30004 returns cnt[7:0] and latches shadow <= cnt[31:8].
  - 0x30005, 0x30006, 0x30007 return shadow[7:0], [15:8], [23:16].
  - The 32-bit cnt increments every cycle after reset and wraps at 2^32.
- Other I/O addresses read 0x00; writes to them are ignored.
- io_buffer_full = tx_count >= TX_DEPTH-2. This gives margin for the CPU's one-cycle reaction.
- FIFOs:
  - A simultaneous push and pop leaves the count unchanged; the pointers wrap modulo depth.
  - A pop on a full FIFO together with a push is accepted.
  - rx push occurs when rx_valid&rx_ready.
  - tx pop occurs when tx_valid&tx_ready.
- Reset values:
  - Outputs: mem_din=0, tx_valid=0, tx_data=0, rx_ready=1, io_buffer_full=0, program_stop=0, tx_overflow=0.
  - Internal state: cnt=0, shadow=0, FIFOs empty, previous-access register = (0,1).
  - RAM contents are not reset.
- Reset mid-operation: in-flight read data is lost (mem_din=0 next cycle) and FIFO contents are discarded.

Decomposition:
- Shared package holds:
  - IO_BASE=32'h30000, IO_CLK=32'h30004.
  - Address and data width constants.
  - The io-decode function on mem_a[17:16].
- One sub-module, byte_fifo (parameter DEPTH; push/pop/full/empty/count), instantiated for rx and tx.
- RAM and counter logic stay inline.

Test Plan:
- Write 0xA5 to 0x00010, next cycle read 0x00010 -> mem_din==0xA5 one cycle after the read address; a read of an unwritten address one cycle later changes mem_din accordingly.
- Feed rx bytes 0x41,0x42; read 0x30000, idle 0x00000, read 0x30000, read 0x30000 again with an idle cycle between -> 0x41, 0x42, then 0x00 (empty); holding 0x30000 for 3 cycles pops only once.
- tx_ready=0, write 14 bytes 0x01..0x0E to 0x30000 -> io_buffer_full rises after the 14th, writes 15 and 16 accepted, 17th dropped with tx_overflow=1; write 0x00 -> tx count unchanged; raise tx_ready -> bytes drain in order 0x01...
- After 0x1234 cycles from reset, read 0x30004..0x30007 on consecutive cycles -> bytes assemble to the counter value sampled at the 0x30004 access, with upper bytes stable despite increments.
- Write 0x30004 -> program_stop=1 sticky, 0x00 appears on tx_data; assert rst_in mid-stream -> all outputs at reset values the next cycle, program_stop=0.
